des_round_engine: RTL

Iterative 16-round DES Feistel core with an on-the-fly key schedule; one round per clock.
- Sits directly upstream of the final-permutation stage (IP^-1).
- Consumes a block that has already passed the initial permutation (IP).
- Produces the 64-bit preoutput R16||L16, which the final-permutation stage maps to ciphertext/plaintext.
- Valid/ready handshakes on both sides.

---
 rtl/des_pkg.sv | 37 +++
 rtl/des_round_engine_f.sv | 50 +++++
 rtl/des_round_engine.sv | 105 ++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared DES constants for the iterative round engine: key-schedule tables,
// rotation schedule, FSM encoding and the round-counter width.
package des_pkg;
  localparam int RND_W = 5;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Rotation amount for round 1..16; out-of-range rounds never reach a register.
  function automatic logic [1:0] shift_of(input logic [RND_W-1:0] rnd);
    logic [1:0] s;
    s = 2'd1;
    for (int i = 1; i <= 16; i++)
      if (rnd == RND_W'(i)) s = 2'(SHIFT[i-1]);
    return s;
  endfunction

  // Bit 27 is DES bit 1 of the half, so "left" moves bits toward bit 27.
  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n,
                                        input logic left);
    if (left) return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    else      return (n == 2'd2) ? {x[1:0], x[27:2]}   : {x[0], x[27:1]};
  endfunction
endpackage

// File: rtl/des_round_engine_f.sv
// DES round function f(R,K): E expansion, subkey XOR, S1..S8, P permutation.
// Vectors are MSB-first: bit 31 of i_r / bit 47 of i_k is DES bit 1.
module des_f (
  input  logic [31:0] i_r,
  input  logic [47:0] i_k,
  output logic [31:0] o_f
);
  localparam int E [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each S-box row-major (row = outer bits, col = inner bits), entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  logic [47:0] w_e;
  logic [47:0] w_x;
  logic [31:0] w_s;

  for (genvar j = 0; j < 48; j++) begin : g_e
    assign w_e[47-j] = i_r[32-E[j]];
  end

  assign w_x = w_e ^ i_k;

  for (genvar s = 0; s < 8; s++) begin : g_sbox
    logic [5:0] w_six;
    logic [5:0] w_idx;
    assign w_six = w_x[47-6*s -: 6];
    assign w_idx = {w_six[5], w_six[0], w_six[4:1]};
    assign w_s[31-4*s -: 4] = 4'(SBOX[s] >> {6'd63 - w_idx, 2'b00});
  end

  for (genvar j = 0; j < 32; j++) begin : g_p
    assign o_f[31-j] = w_s[32-P[j]];
  end
endmodule

// File: rtl/des_round_engine.sv
// Iterative 16-round DES Feistel core, one round per clock, key schedule
// computed on the fly from the registered C/D halves in either direction.
module des_round_engine
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:64] in_block,
  input  logic [1:64] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] out_block
);
  state_t           r_state, w_state_nxt;
  logic [31:0]      r_l, r_r;
  logic [27:0]      r_c, r_d;
  logic [RND_W-1:0] r_round;
  logic             r_dec;

  logic [55:0] w_pc1;
  logic [1:0]  w_sh_enc, w_sh_dec;
  logic [27:0] w_c_rol, w_d_rol, w_c_nxt, w_d_nxt;
  logic [55:0] w_cd;
  logic [47:0] w_k;
  logic [31:0] w_f;
  logic        w_unused_parity;

  for (genvar j = 0; j < 56; j++) begin : g_pc1
    assign w_pc1[55-j] = in_key[PC1[j]];
  end
  assign w_unused_parity = ^{in_key[8], in_key[16], in_key[24], in_key[32],
                             in_key[40], in_key[48], in_key[56], in_key[64]};

  // Encrypt rotates before use; decrypt uses C/D as-is and unwinds afterwards.
  assign w_sh_enc = shift_of(r_round);
  assign w_sh_dec = shift_of(RND_W'(17) - r_round);
  assign w_c_rol  = rot28(r_c, w_sh_enc, 1'b1);
  assign w_d_rol  = rot28(r_d, w_sh_enc, 1'b1);
  assign w_cd     = r_dec ? {r_c, r_d} : {w_c_rol, w_d_rol};
  assign w_c_nxt  = r_dec ? rot28(r_c, w_sh_dec, 1'b0) : w_c_rol;
  assign w_d_nxt  = r_dec ? rot28(r_d, w_sh_dec, 1'b0) : w_d_rol;

  for (genvar j = 0; j < 48; j++) begin : g_pc2
    assign w_k[47-j] = w_cd[56-PC2[j]];
  end

  des_f u_f (
    .i_r (r_r),
    .i_k (w_k),
    .o_f (w_f)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN:  if (r_round == RND_W'(16)) w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_l     <= '0;
      r_r     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_round <= '0;
      r_dec   <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_l     <= in_block[1:32];
      r_r     <= in_block[33:64];
      r_c     <= w_pc1[55:28];
      r_d     <= w_pc1[27:0];
      r_dec   <= in_decrypt;
      r_round <= RND_W'(1);
    end else if (r_state == RUN) begin
      r_l     <= r_r;
      r_r     <= r_l ^ w_f;
      r_c     <= w_c_nxt;
      r_d     <= w_d_nxt;
      r_round <= r_round + RND_W'(1);
    end
  end

  // Final swap lives here rather than in a 17th round.
  assign out_block = {r_r, r_l};
endmodule
